// File: rtl/fact_pkg.sv
// Shared constants and types for the factorial accelerator bus master.
package fact_pkg;

   // Accelerator register map
   localparam logic [1:0] FACT_A_N    = 2'b00;
   localparam logic [1:0] FACT_A_GO   = 2'b01;
   localparam logic [1:0] FACT_A_STAT = 2'b10;
   localparam logic [1:0] FACT_A_RES  = 2'b11;

   // STATUS register bit positions
   localparam int unsigned ST_DONE = 0;
   localparam int unsigned ST_ERR  = 1;

   // Engine sequencing states
   typedef enum logic [2:0] {
      IDLE,
      WR_N,
      WR_GO,
      CLR_GO,
      POLL,
      RD_RES,
      RESP
   } fact_state_t;

endpackage

// File: rtl/fact_master_if.sv
// Request/response handshakes plus the accelerator register bus.
interface fact_master_if #(
   parameter int DW = 32,
   parameter int NW = 4
);
   logic          req_valid;
   logic          req_ready;
   logic [NW-1:0] req_n;
   logic          resp_valid;
   logic          resp_ready;
   logic [DW-1:0] resp_result;
   logic          resp_err;
   logic          resp_timeout;
   logic          busy;
   logic [1:0]    a;
   logic          we;
   logic [DW-1:0] wd;
   logic [DW-1:0] rd;

   // Engine side
   modport master (
      input  req_valid, req_n, resp_ready, rd,
      output req_ready, resp_valid, resp_result, resp_err, resp_timeout,
             busy, a, we, wd
   );

   // Requester / accelerator side
   modport slave (
      output req_valid, req_n, resp_ready, rd,
      input  req_ready, resp_valid, resp_result, resp_err, resp_timeout,
             busy, a, we, wd
   );
endinterface

// File: rtl/fact_poll_timer.sv
// Counts STATUS polls; flags the poll that completes the allowed budget.
module fact_poll_timer #(
   parameter int unsigned POLL_LIMIT = 1024,
   parameter int unsigned CW         = 11
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam logic [CW-1:0] LIMIT = CW'(POLL_LIMIT);
   localparam logic [CW-1:0] LAST  = CW'(POLL_LIMIT - 1);

   logic [CW-1:0] count;

   // Poll counter: cleared on reset/clear, holds once the limit is reached
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en && (count != LIMIT)) begin
         count <= count + CW'(1);
      end
   end

   // Expiry is signalled during the enabled poll that brings the count to the limit,
   // so exactly POLL_LIMIT status reads happen before the timeout.
   assign expired = en && (count == LAST);

endmodule

// File: rtl/fact_master.sv
// Bus-initiator engine: writes N, pulses GO, polls STATUS, reads RESULT.
module fact_master
   import fact_pkg::*;
#(
   parameter int DW         = 32,
   parameter int NW         = 4,
   parameter int POLL_LIMIT = 1024,
   parameter int CW         = 11
) (
   input  logic          clk,
   input  logic          rst,
   fact_master_if.master bus
);
   fact_state_t state;
   logic        err_q;
   logic        hit;
   logic        poll_en;
   logic        poll_clr;
   logic        poll_expired;

   assign hit      = bus.rd[ST_DONE] | bus.rd[ST_ERR];
   assign poll_en  = (state == POLL) && !hit;
   assign poll_clr = (state == RESP) && bus.resp_ready;

   fact_poll_timer #(
      .POLL_LIMIT(POLL_LIMIT),
      .CW        (CW)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (poll_clr),
      .en     (poll_en),
      .expired(poll_expired)
   );

   // Sequencer; bus and response outputs are registered alongside the state
   // so each state's bus values appear in the cycle that state is occupied.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         err_q            <= 1'b0;
         bus.a            <= FACT_A_N;
         bus.we           <= 1'b0;
         bus.wd           <= '0;
         bus.req_ready    <= 1'b1;
         bus.resp_valid   <= 1'b0;
         bus.resp_result  <= '0;
         bus.resp_err     <= 1'b0;
         bus.resp_timeout <= 1'b0;
         bus.busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  state         <= WR_N;
                  bus.req_ready <= 1'b0;
                  bus.busy      <= 1'b1;
                  bus.a         <= FACT_A_N;
                  bus.we        <= 1'b1;
                  bus.wd        <= DW'(bus.req_n);
               end
            end
            WR_N: begin
               state  <= WR_GO;
               bus.a  <= FACT_A_GO;
               bus.we <= 1'b1;
               bus.wd <= DW'(1);
            end
            WR_GO: begin
               state  <= CLR_GO;
               bus.a  <= FACT_A_GO;
               bus.we <= 1'b1;
               bus.wd <= '0;
            end
            CLR_GO: begin
               state  <= POLL;
               bus.a  <= FACT_A_STAT;
               bus.we <= 1'b0;
               bus.wd <= '0;
            end
            POLL: begin
               if (hit) begin
                  err_q <= bus.rd[ST_ERR];
                  state <= RD_RES;
                  bus.a <= FACT_A_RES;
               end else if (poll_expired) begin
                  state            <= RESP;
                  bus.a            <= FACT_A_N;
                  bus.resp_valid   <= 1'b1;
                  bus.resp_timeout <= 1'b1;
                  bus.resp_err     <= 1'b0;
                  bus.resp_result  <= '0;
               end
            end
            RD_RES: begin
               state           <= RESP;
               bus.a           <= FACT_A_N;
               bus.resp_valid  <= 1'b1;
               bus.resp_err    <= err_q;
               bus.resp_result <= err_q ? '0 : bus.rd;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  state            <= IDLE;
                  bus.resp_valid   <= 1'b0;
                  bus.req_ready    <= 1'b1;
                  bus.busy         <= 1'b0;
                  bus.resp_result  <= '0;
                  bus.resp_err     <= 1'b0;
                  bus.resp_timeout <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fact_master.md
Name: fact_master

Overview:
- Bus-initiator engine that drives the 2-bit memory-mapped register interface of the factorial accelerator on behalf of a requester, such as a test harness or a DMA-style offload path from the MIPS32 core.
- Accepts an operand n on a valid/ready handshake.
- Performs the register sequence: write n, pulse go, poll status, read result.
- Returns the result and error flags on a second valid/ready handshake.
- Sits on the initiator side of the accelerator's address decoder.

Parameters:
- DW, 32, data width of the register bus (wd/rd/result).
- NW, 4, width of the operand n. It is zero-extended onto wd.
- POLL_LIMIT, 1024, maximum status reads before a timeout is declared (>=1).
- CW, 11, poll counter width. Must satisfy 2^CW > POLL_LIMIT.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  engine can accept a request
- req_n  in  NW  operand
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_result  out  DW  factorial result (0 when resp_err=1)
- resp_err  out  1  accelerator reported error (status bit 1)
- resp_timeout  out  1  done never seen within POLL_LIMIT polls
- busy  out  1  high in every state except IDLE
- a  out  2  register address to accelerator
- we  out  1  write enable to accelerator
- wd  out  DW  write data
- rd  in  DW  read data. It is combinational: valid in the same cycle that a is driven.

Behaviour:
- Register map: 00=N (write), 01=GO (write, bit0), 10=STATUS (read; bit0 done, bit1 err), 11=RESULT (read).
- Reset values: state=IDLE, a=00, we=0, wd=0, req_ready=1, resp_valid=0, resp_result=0, resp_err=0, resp_timeout=0, busy=0, poll count=0.
- States and transitions (one per cycle unless stated):
  - IDLE: req_ready=1. On req_valid, capture req_n and go to WR_N.
  - WR_N: a=00, we=1, wd=zero-extended n. Next: WR_GO.
  - WR_GO: a=01, we=1, wd=1. Next: CLR_GO.
  - CLR_GO: a=01, we=1, wd=0. Next: POLL.
  - POLL: a=10, we=0, sample rd.
    - If done=1 or err=1: latch err, go to RD_RES.
    - Else increment the count. When the count reaches POLL_LIMIT, set timeout and go to RESP.
  - RD_RES: a=11, we=0. Latch resp_result = err ? 0 : rd. Next: RESP.
  - RESP: resp_valid=1, outputs held stable. On resp_ready, go to IDLE, clear the poll count, and drop resp_valid the next cycle.
- we is high only in WR_N, WR_GO and CLR_GO. In all other states a=00, we=0, wd=0, except the a value required by POLL and RD_RES.
- req_ready is high only in IDLE. A request asserted while busy is held off with no loss.
- Fixed latency for an immediate-done accelerator:
  - Request accepted at cycle 0.
  - First poll at cycle 4.
  - resp_valid at cycle 6.
- Priority: err has priority over done. When both are set, resp_err=1 and resp_result=0.
- Timeout:
  - resp_timeout=1, resp_err=0, resp_result=0.
  - The accelerator is left as is. No GO clear is re-issued.
- When resp_valid and resp_ready are both high in RESP, the engine returns to IDLE. The next request cannot be accepted in that same cycle; the earliest acceptance is the following cycle.
- rst mid-operation, in any state: return to IDLE with reset values next edge, with no further bus writes. An in-flight response is discarded.
- Poll count saturates logic: it is never compared past POLL_LIMIT and never wraps.

Decomposition:
- Shared package fact_pkg holds:
  - address constants FACT_A_N=2'b00, FACT_A_GO=2'b01, FACT_A_STAT=2'b10, FACT_A_RES=2'b11
  - status bit indices ST_DONE=0, ST_ERR=1
  - state encoding localparams for IDLE, WR_N, WR_GO, CLR_GO, POLL, RD_RES, RESP
- One natural sub-module: fact_poll_timer. It is a CW-bit counter with clear/enable inputs and an expired output at POLL_LIMIT.

Test Plan:
- Behavioural accelerator model with done after 8 cycles; request n=5 -> bus writes 00←5, 01←1, 01←0; resp_result=120, resp_err=0, resp_timeout=0.
- n=0 with done immediate -> resp_valid exactly 6 cycles after acceptance; resp_result=1.
- n=13 with the model asserting err (status=2'b10) -> resp_err=1, resp_result=0, RESULT address not required to be used beyond the one RD_RES cycle.
- Model never asserts done, POLL_LIMIT=16 -> exactly 16 STATUS reads; resp_timeout=1, resp_err=0, resp_result=0.
- Hold resp_ready=0 for 10 cycles -> resp_valid and data stable; req_ready=0; a second req_valid is not accepted until the cycle after the handshake.
- Assert rst during POLL -> next cycle: state IDLE, we=0, a=00, resp_valid=0, req_ready=1; a new request n=3 then completes with result 6.
